// File: rtl/misc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : misc_pkg
// Description : Shared types and constants for the MISC-V sequencer: the
//               sequencer state encoding, opcode nibbles and the NOP
//               instruction used as the instruction-register reset value.
// Revision    : 1.0 - initial release
// ============================================================================
package misc_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  localparam logic [3:0] OP_AND  = 4'h0;
  localparam logic [3:0] OP_OR   = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_NOP  = 4'h4;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [7:0] NOP_INSTR = 8'h40;

  // Opcodes 5..E are undefined, except whichever one is configured as halt.
  function automatic logic is_undefined(input logic [3:0] op, input logic [3:0] halt_op);
    return (op >= 4'h5) && (op <= 4'hE) && (op != halt_op);
  endfunction

endpackage : misc_pkg
`default_nettype wire

// File: rtl/misc_pc_reg.sv
`default_nettype none
// ============================================================================
// Module      : misc_pc_reg
// Description : Program counter with synchronous reset, synchronous clear
//               (restart from address 0) and increment that wraps modulo
//               2^PC_W. Clear has priority over increment.
// Revision    : 1.0 - initial release
// ============================================================================
module misc_pc_reg #(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            inc,
  output logic [PC_W-1:0] pc
);

  // PC update: reset/clear return to 0, increment wraps naturally at 2^PC_W.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      pc <= '0;
    end else if (inc) begin
      pc <= pc + PC_W'(1);
    end
  end

endmodule : misc_pc_reg
`default_nettype wire

// File: rtl/misc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : misc_sequencer
// Description : Fetch/decode/execute/writeback controller for the 8-bit
//               MISC-V core. Fetches one byte per instruction over a
//               req/valid handshake, holds it in the instruction register and
//               strobes register read, ALU and writeback in turn.
//               Optional build macro MISCV_SINGLE_STEP_EN: each start pulse
//               in IDLE executes exactly one instruction, then returns to IDLE.
// Revision    : 1.0 - initial release
// ============================================================================
module misc_sequencer
  import misc_pkg::*;
#(
  parameter int         PC_W    = 8,
  parameter logic [3:0] HALT_OP = 4'hF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [7:0]      imem_rdata,
  output logic [7:0]      instr,
  input  logic            dec_wr_enable,
  output logic            rf_rd_en,
  output logic            alu_en,
  output logic            wb_strobe,
  output logic            illegal,
  output logic            busy,
  output logic            halted
);

  state_t          state;
  state_t          state_next;
  logic [3:0]      opcode;
  logic [PC_W-1:0] pc;
  logic            pc_clear;
  logic            pc_inc;

  assign opcode    = instr[7:4];
  assign imem_addr = pc;

  // Restarting from HALT goes back to address 0; every writeback advances.
  assign pc_clear = (state == HALT) && start;
  assign pc_inc   = (state == WB);

  misc_pc_reg #(
    .PC_W (PC_W)
  ) u_pc_reg (
    .clk   (clk),
    .rst   (rst),
    .clear (pc_clear),
    .inc   (pc_inc),
    .pc    (pc)
  );

  // State register; reset abandons any instruction or fetch in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Instruction register captures the fetched byte only while fetching,
  // so a late rvalid after reset or in any other state is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr <= NOP_INSTR;
    end else if ((state == FETCH) && imem_rvalid) begin
      instr <= imem_rdata;
    end
  end

  // Next-state logic and state-decoded strobes.
  always_comb begin
    state_next = state;
    imem_req   = 1'b0;
    rf_rd_en   = 1'b0;
    alu_en     = 1'b0;
    wb_strobe  = 1'b0;
    illegal    = 1'b0;
    busy       = 1'b0;
    halted     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_next = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        busy     = 1'b1;
        if (imem_rvalid) state_next = DECODE;
      end
      DECODE: begin
        rf_rd_en = 1'b1;
        busy     = 1'b1;
        if (opcode == HALT_OP) begin
          state_next = HALT;
        end else begin
          // Undefined opcodes are flagged and then run through as a NOP.
          illegal    = is_undefined(opcode, HALT_OP);
          state_next = EXEC;
        end
      end
      EXEC: begin
        alu_en     = 1'b1;
        busy       = 1'b1;
        state_next = WB;
      end
      WB: begin
        busy      = 1'b1;
        // Only the register-writing ALU ops may write back.
        wb_strobe = dec_wr_enable && (opcode <= OP_SUB);
`ifdef MISCV_SINGLE_STEP_EN
        state_next = IDLE;
`else
        state_next = FETCH;
`endif
      end
      HALT: begin
        halted = 1'b1;
        if (start) state_next = FETCH;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule : misc_sequencer
`default_nettype wire

// File: tb/tb_misc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_misc_sequencer
// Description : Self-checking bench for misc_sequencer. Drives an instruction
//               memory with random wait states and random programs, and
//               compares every strobe against expectations derived from the
//               instruction-level behaviour (one instruction = fetch with
//               waits, decode, exec, writeback; pc advances mod 2^PC_W).
//               Honours MISCV_SINGLE_STEP_EN when the design is built with it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_misc_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_rvalid;
  logic [7:0] imem_rdata;
  logic [7:0] instr;
  logic       dec_wr_enable;
  logic       rf_rd_en, alu_en, wb_strobe, illegal, busy, halted;

  // Second instance with a 2-bit PC, fed by a zero-wait memory.
  logic       start2;
  logic       req2;
  logic [1:0] addr2;
  logic [7:0] instr2;
  logic       rf2, alu2, wb2, ill2, busy2, halt2;

  int n_assert = 0;
  int n_fail   = 0;
  int exp_pc   = 0;

  always #5 clk = ~clk;

  misc_sequencer #(.PC_W(8), .HALT_OP(4'hF)) dut (
    .clk (clk), .rst (rst), .start (start),
    .imem_req (imem_req), .imem_addr (imem_addr),
    .imem_rvalid (imem_rvalid), .imem_rdata (imem_rdata),
    .instr (instr), .dec_wr_enable (dec_wr_enable),
    .rf_rd_en (rf_rd_en), .alu_en (alu_en), .wb_strobe (wb_strobe),
    .illegal (illegal), .busy (busy), .halted (halted)
  );

  misc_sequencer #(.PC_W(2), .HALT_OP(4'hF)) dut2 (
    .clk (clk), .rst (rst), .start (start2),
    .imem_req (req2), .imem_addr (addr2),
    .imem_rvalid (req2), .imem_rdata (8'h12),
    .instr (instr2), .dec_wr_enable (1'b0),
    .rf_rd_en (rf2), .alu_en (alu2), .wb_strobe (wb2),
    .illegal (ill2), .busy (busy2), .halted (halt2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_req"},     imem_req,  0);
    chk({tag, "_rf"},      rf_rd_en,  0);
    chk({tag, "_alu"},     alu_en,    0);
    chk({tag, "_wb"},      wb_strobe, 0);
    chk({tag, "_illegal"}, illegal,   0);
    chk({tag, "_busy"},    busy,      0);
    chk({tag, "_halted"},  halted,    0);
    chk({tag, "_instr"},   instr,     8'h40);
    chk({tag, "_addr"},    imem_addr, 0);
  endtask

  // Runs one instruction; entered on a negedge with the DUT fetching.
  task automatic run_instr(input logic [7:0] ins, input int waits, input logic wr);
    logic [3:0] op;
    op = ins[7:4];
    dec_wr_enable = wr;
    for (int w = 0; w <= waits; w++) begin
      chk("fetch_req",  imem_req,  1);
      chk("fetch_addr", imem_addr, exp_pc[7:0]);
      chk("fetch_busy", busy,      1);
      chk("fetch_rf",   rf_rd_en,  0);
      imem_rvalid = (w == waits);
      imem_rdata  = (w == waits) ? ins : 8'($urandom);
      @(negedge clk);
    end
    imem_rvalid = 1'b0;
    imem_rdata  = 8'($urandom);
    chk("dec_req",     imem_req, 0);
    chk("dec_rf",      rf_rd_en, 1);
    chk("dec_alu",     alu_en,   0);
    chk("dec_instr",   instr,    ins);
    chk("dec_illegal", illegal,  (op >= 4'h5 && op <= 4'hE) ? 1 : 0);
    @(negedge clk);
    if (op == 4'hF) begin
      chk("halt_halted", halted,    1);
      chk("halt_busy",   busy,      0);
      chk("halt_rf",     rf_rd_en,  0);
      chk("halt_addr",   imem_addr, exp_pc[7:0]);
      return;
    end
    chk("exec_alu",     alu_en,    1);
    chk("exec_rf",      rf_rd_en,  0);
    chk("exec_illegal", illegal,   0);
    chk("exec_wb",      wb_strobe, 0);
    @(negedge clk);
    chk("wb_strobe", wb_strobe, (wr && op <= 4'h3) ? 1 : 0);
    chk("wb_alu",    alu_en,    0);
    chk("wb_busy",   busy,      1);
    exp_pc = (exp_pc + 1) % 256;
    @(negedge clk);
`ifdef MISCV_SINGLE_STEP_EN
    chk("step_idle_busy", busy,      0);
    chk("step_idle_req",  imem_req,  0);
    chk("step_idle_halt", halted,    0);
    chk("step_idle_addr", imem_addr, exp_pc[7:0]);
    @(negedge clk);
    chk("step_idle_hold", imem_req,  0);
    pulse_start;
`endif
  endtask

  initial begin
    int e2;
    int nf;
    logic [7:0] ins;
    rst = 1'b1; start = 1'b0; start2 = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = 8'h00; dec_wr_enable = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_idle("reset");

    // 2-bit PC wraps 0,1,2,3,0,...
    e2 = 0; nf = 0;
    start2 = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (req2) begin
        chk("pcw2_addr", addr2, e2[1:0]);
        e2 = (e2 + 1) % 4;
        nf++;
      end
    end
    start2 = 1'b0;
    chk("pcw2_fetches", (nf >= 5) ? 1 : 0, 1);

    // Directed program ending in HALT; pc stays at the halt address.
    pulse_start;
    run_instr(8'h21, 0, 1'b1);
    run_instr(8'h03, 0, 1'b1);
    run_instr(8'hF0, 0, 1'b1);
    repeat (3) begin
      @(negedge clk);
      chk("halt_stay",     halted,    1);
      chk("halt_stay_req", imem_req,  0);
      chk("halt_stay_pc",  imem_addr, 2);
    end

    // Restart from HALT at address 0; wait states, NOP and illegal opcode.
    pulse_start;
    exp_pc = 0;
    run_instr(8'h4A, 3, 1'b1);
    run_instr(8'h75, 0, 1'b1);

    // Random non-halt program long enough to wrap the 8-bit pc.
    repeat (280) begin
      ins = {4'($urandom_range(0, 14)), 4'($urandom)};
      run_instr(ins, $urandom_range(0, 2), 1'($urandom));
    end

    // Reset while a fetch is pending, then a stray rvalid.
    chk("pend_req", imem_req, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_pc = 0;
    chk_idle("rst_fetch");
    imem_rvalid = 1'b1; imem_rdata = 8'h21;
    @(negedge clk);
    imem_rvalid = 1'b0;
    chk_idle("stray1");

    // Reset during EXEC, then a stray rvalid.
    pulse_start;
    imem_rvalid = 1'b1; imem_rdata = 8'h21;
    @(negedge clk);
    imem_rvalid = 1'b0;
    @(negedge clk);
    chk("pre_rst_exec", alu_en, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_idle("rst_exec");
    imem_rvalid = 1'b1; imem_rdata = 8'h03;
    @(negedge clk);
    imem_rvalid = 1'b0;
    chk_idle("stray2");

    // Short program after reset: two instructions retire, then halt at 2.
    pulse_start;
    run_instr(8'h10, 1, 1'b1);
    run_instr(8'h20, 0, 1'b0);
    run_instr(8'hF3, 0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_misc_sequencer
`default_nettype wire
